// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel frame controller.
// FSM state encoding and default frame geometry / detector latency.
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        ACTIVE,
        DRAIN
    } state_t;

    localparam int DEF_WIDTH       = 640;
    localparam int DEF_HEIGHT      = 480;
    localparam int DEF_DET_LATENCY = 2;

endpackage

// File: rtl/sobel_valid_pipe.sv
// Delay line for the window valid/eol/eof tags, aligned to the detector.
// DEPTH register stages with synchronous clear; DEPTH=0 is a wire.
module sobel_valid_pipe #(
    parameter int DEPTH = 2,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          i_clr,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_d
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign o_d = i_d;
        end else begin : g_pipe
            logic [DW-1:0] r_sr [DEPTH];

            // shift tags one stage per cycle; clear drops everything in flight
            always_ff @(posedge clk) begin
                if (i_clr) begin
                    for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
                end else begin
                    r_sr[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
                end
            end

            assign o_d = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencing for a 3x3 Sobel edge pipeline: position tracking,
// window/result strobes, drain. Optional FRAME_STATS_EN adds frame_edges.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HEIGHT      = DEF_HEIGHT,
    parameter int DET_LATENCY = DEF_DET_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_sof,
    output logic in_ready,
    output logic lb_shift,
    output logic win_valid,
    input  logic edge_in,
    output logic out_valid,
    output logic out_edge,
    output logic out_eol,
    output logic out_eof,
    output logic busy,
    output logic done,
    output logic err_sof
`ifdef FRAME_STATS_EN
    ,
    output logic [$clog2(WIDTH*HEIGHT):0] frame_edges
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int DW = $clog2(DET_LATENCY + 2);
    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);
    localparam logic [DW-1:0] DRN_LAST = DW'(DET_LATENCY);

    state_t        r_state, w_nstate;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [DW-1:0] r_drn;
    logic          r_win_valid, r_win_eol, r_win_eof, r_err_sof;
    logic          w_go, w_start, w_restart, w_adv;
    logic          w_at_origin, w_last, w_prime_end, w_interior;
    logic [2:0]    w_pipe;

    assign w_go        = in_valid & ~rst;
    assign w_at_origin = (r_col == '0) && (r_row == '0);
    assign w_last      = (r_col == LAST_COL) && (r_row == LAST_ROW);
    assign w_prime_end = (r_row == RW'(2)) && (r_col == CW'(1));
    assign w_interior  = (r_row >= RW'(2)) && (r_col >= CW'(2));

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nstate;
    end

    // next state, handshake and frame-control strobes
    always_comb begin
        w_nstate  = r_state;
        in_ready  = 1'b0;
        lb_shift  = 1'b0;
        done      = 1'b0;
        w_start   = 1'b0;
        w_restart = 1'b0;
        w_adv     = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = ~rst;
                if (w_go && in_sof) begin
                    lb_shift = 1'b1;
                    w_start  = 1'b1;
                    w_nstate = PRIME;
                end
            end
            PRIME, ACTIVE: begin
                in_ready = ~rst;
                if (w_go) begin
                    lb_shift = 1'b1;
                    if (in_sof && !w_at_origin) begin
                        w_restart = 1'b1;
                        w_nstate  = PRIME;
                    end else begin
                        w_adv = 1'b1;
                        if (w_last)
                            w_nstate = DRAIN;
                        else if (r_state == PRIME && w_prime_end)
                            w_nstate = ACTIVE;
                    end
                end
            end
            DRAIN: begin
                if (r_drn == DRN_LAST) begin
                    done     = ~rst;
                    w_nstate = IDLE;
                end
            end
            default: w_nstate = IDLE;
        endcase
    end

    // pixel position; the pixel that starts a frame is (0,0)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_start || w_restart) begin
            r_col <= CW'(1);
            r_row <= '0;
        end else if (w_adv) begin
            if (r_col == LAST_COL) begin
                r_col <= '0;
                r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // drain cycle counter, runs only while in DRAIN
    always_ff @(posedge clk) begin
        if (rst || r_state != DRAIN) r_drn <= '0;
        else                         r_drn <= r_drn + 1'b1;
    end

    // window strobe and tags, one cycle after the accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_valid <= 1'b0;
            r_win_eol   <= 1'b0;
            r_win_eof   <= 1'b0;
            r_err_sof   <= 1'b0;
        end else begin
            r_win_valid <= w_adv & w_interior;
            r_win_eol   <= w_adv & w_interior & (r_col == LAST_COL);
            r_win_eof   <= w_adv & w_interior & w_last;
            r_err_sof   <= w_restart;
        end
    end

    sobel_valid_pipe #(
        .DEPTH (DET_LATENCY),
        .DW    (3)
    ) u_pipe (
        .clk   (clk),
        .i_clr (rst),
        .i_d   ({r_win_valid, r_win_eol, r_win_eof}),
        .o_d   (w_pipe)
    );

    assign win_valid = r_win_valid;
    assign out_valid = w_pipe[2];
    assign out_eol   = w_pipe[1];
    assign out_eof   = w_pipe[0];
    assign out_edge  = out_valid & edge_in;
    assign busy      = (r_state != IDLE);
    assign err_sof   = r_err_sof;

`ifdef FRAME_STATS_EN
    logic [$clog2(WIDTH*HEIGHT):0] r_edge_cnt;

    // per-frame edge count, latched with the last result of the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge_cnt  <= '0;
            frame_edges <= '0;
        end else begin
            if (w_start || w_restart)
                r_edge_cnt <= '0;
            else if (out_valid && edge_in)
                r_edge_cnt <= r_edge_cnt + 1'b1;
            if (out_valid && out_eof)
                frame_edges <= r_edge_cnt + {{$clog2(WIDTH*HEIGHT){1'b0}}, edge_in};
        end
    end
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl (WIDTH=5, HEIGHT=4, DET_LATENCY=2).
// Frame-position model checked every cycle plus literal pins per scenario.
module tb_sobel_frame_ctrl;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int L  = 2;
    localparam int NC = 2048;

    logic clk = 1'b0;
    logic rst, in_valid, in_sof, edge_in;
    logic in_ready, lb_shift, win_valid;
    logic out_valid, out_edge, out_eol, out_eof;
    logic busy, done, err_sof;
`ifdef FRAME_STATS_EN
    logic [$clog2(W*H):0] frame_edges;
`endif

    sobel_frame_ctrl #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .DET_LATENCY (L)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_ready    (in_ready),
        .lb_shift    (lb_shift),
        .win_valid   (win_valid),
        .edge_in     (edge_in),
        .out_valid   (out_valid),
        .out_edge    (out_edge),
        .out_eol     (out_eol),
        .out_eof     (out_eof),
        .busy        (busy),
        .done        (done),
        .err_sof     (err_sof)
`ifdef FRAME_STATS_EN
        ,
        .frame_edges (frame_edges)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit e_ov[NC], e_eol[NC], e_eof[NC], e_win[NC], e_err[NC], e_done[NC];
    bit m_infr = 1'b0;
    int m_pos = 0, m_drain = 0, m_cnt = 0, m_fe = 0, res_n = 0;
    bit x_rdy, x_busy, x_done, x_lb, acc;
    int rr, cc;

    logic [5:0] edge_pat = 6'b111010;
    assign edge_in = (res_n < 6) ? edge_pat[res_n] : 1'b0;

    int obs_lb = 0, obs_ov = 0, obs_err = 0, obs_done = 0, done_cyc = -1;
    int acc_cyc[64];
    int ov_cyc[16];
    logic [7:0] eol_mask = '0, eof_mask = '0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
        end
    endtask

    // model + per-cycle compare, away from the active edge
    always @(negedge clk) begin
        x_rdy  = !rst && m_drain == 0;
        x_busy = m_infr || m_drain > 0;
        x_done = e_done[cyc] && !rst;
        acc    = in_valid && x_rdy;
        x_lb   = acc && (m_infr || in_sof);

        chk("in_ready", int'(in_ready), int'(x_rdy));
        chk("lb_shift", int'(lb_shift), int'(x_lb));
        chk("busy", int'(busy), int'(x_busy));
        chk("done", int'(done), int'(x_done));
        chk("win_valid", int'(win_valid), int'(e_win[cyc]));
        chk("err_sof", int'(err_sof), int'(e_err[cyc]));
        chk("out_valid", int'(out_valid), int'(e_ov[cyc]));
        chk("out_eol", int'(out_eol), int'(e_eol[cyc]));
        chk("out_eof", int'(out_eof), int'(e_eof[cyc]));
        chk("out_edge", int'(out_edge), int'(e_ov[cyc] && edge_in));
`ifdef FRAME_STATS_EN
        chk("frame_edges", int'(frame_edges), m_fe);
`endif

        if (lb_shift && obs_lb < 64) acc_cyc[obs_lb] = cyc;
        if (lb_shift) obs_lb++;
        if (out_valid) begin
            if (obs_ov < 8) begin
                ov_cyc[obs_ov] = cyc;
                eol_mask[obs_ov] = out_eol;
                eof_mask[obs_ov] = out_eof;
            end
            obs_ov++;
        end
        if (done) begin
            obs_done++;
            done_cyc = cyc;
        end
        if (err_sof) obs_err++;

        if (rst) begin
            m_infr = 1'b0; m_pos = 0; m_drain = 0;
            m_cnt = 0; m_fe = 0; res_n = 0;
            for (int k = cyc + 1; k < NC; k++) begin
                e_ov[k] = 0; e_eol[k] = 0; e_eof[k] = 0;
                e_win[k] = 0; e_err[k] = 0; e_done[k] = 0;
            end
        end else begin
            if (e_ov[cyc] && e_eof[cyc]) m_fe = m_cnt + int'(edge_in);
            if (acc && in_sof) m_cnt = 0;
            else if (e_ov[cyc] && edge_in) m_cnt++;
            if (e_ov[cyc]) res_n++;
            if (m_drain > 0) m_drain--;
            if (acc && m_infr && in_sof) begin
                e_err[cyc+1] = 1;
                m_pos = 1;
                res_n = 0;
            end else if (acc && m_infr) begin
                rr = m_pos / W;
                cc = m_pos % W;
                if (rr >= 2 && cc >= 2) begin
                    e_win[cyc+1]  = 1;
                    e_ov[cyc+1+L] = 1;
                    e_eol[cyc+1+L] = (cc == W - 1);
                    e_eof[cyc+1+L] = (m_pos == W * H - 1);
                end
                m_pos++;
                if (m_pos == W * H) begin
                    m_infr = 1'b0;
                    m_pos = 0;
                    m_drain = L + 1;
                    e_done[cyc+L+1] = 1;
                end
            end else if (acc && in_sof) begin
                m_infr = 1'b1;
                m_pos = 1;
                res_n = 0;
            end
        end
        cyc++;
    end

    task automatic px(input bit v, input bit s);
        @(posedge clk);
        #1;
        in_valid = v;
        in_sof   = s;
    endtask

    task automatic clr_obs();
        obs_lb = 0; obs_ov = 0; obs_err = 0; obs_done = 0;
        done_cyc = -1; eol_mask = '0; eof_mask = '0;
    endtask

    task automatic frame(input int n, input int gap, input int sof_at);
        for (int i = 0; i < n; i++) begin
            px(1'b1, (i == 0) || (i == sof_at));
            for (int g = 0; g < gap; g++) px(1'b0, 1'b0);
        end
        px(1'b0, 1'b0);
    endtask

    int pix[6] = '{12, 13, 14, 17, 18, 19};

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_sof = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        chk("rst_no_shift", obs_lb, 0);
        chk("rst_no_out", obs_ov, 0);
        @(negedge clk);
        chk("ready_after_rst", int'(in_ready), 1);

        // back-to-back frame
        px(1'b0, 1'b0);
        clr_obs();
        frame(20, 0, -1);
        repeat (8) px(1'b0, 1'b0);
        chk("b2b_shifts", obs_lb, 20);
        chk("b2b_results", obs_ov, 6);
        chk("b2b_first_lat", ov_cyc[0] - acc_cyc[12], 3);
        chk("b2b_eol_mask", int'(eol_mask), 8'b0010_0100);
        chk("b2b_eof_mask", int'(eof_mask), 8'b0010_0000);
        chk("b2b_done_lat", done_cyc - acc_cyc[19], 3);
        chk("b2b_done_cnt", obs_done, 1);
`ifdef FRAME_STATS_EN
        chk("stats_edges", int'(frame_edges), 4);
`endif

        // gapped frame
        clr_obs();
        frame(20, 1, -1);
        repeat (8) px(1'b0, 1'b0);
        chk("gap_shifts", obs_lb, 20);
        chk("gap_results", obs_ov, 6);
        for (int k = 0; k < 6; k++)
            chk("gap_lat", ov_cyc[k] - acc_cyc[pix[k]], 3);
        chk("gap_eol_mask", int'(eol_mask), 8'b0010_0100);

        // sof inside a frame restarts it
        clr_obs();
        frame(27, 0, 7);
        repeat (8) px(1'b0, 1'b0);
        chk("err_pulses", obs_err, 1);
        chk("err_results", obs_ov, 6);
        chk("err_first_lat", ov_cyc[0] - acc_cyc[7 + 12], 3);
        chk("err_done_cnt", obs_done, 1);

        // reset mid-frame drops results in flight
        for (int i = 0; i < 14; i++) px(1'b1, i == 0);
        @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clr_obs();
        repeat (8) px(1'b0, 1'b0);
        chk("rst_mid_results", obs_ov, 0);
        @(negedge clk);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ready", int'(in_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
